// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: Moore FSM sequencing RV32I instructions over a shared ALU and memory port.
module multicycle_control_unit #(
    parameter bit USE_MEM_READY = 1'b1,
    parameter bit EN_BNE        = 1'b1,
    parameter bit EN_UTYPE      = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       RegWrite,
    output logic [2:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       IllegalInstr,
    output logic [3:0] State
);
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3,
        MEMWB = 4'd4, MEMWRITE = 4'd5, EXECUTER = 4'd6, EXECUTEI = 4'd7,
        ALUWB = 4'd8, BRANCH = 4'd9, JAL = 4'd10, JALR = 4'd11,
        LUI = 4'd12, AUIPC = 4'd13
    } state_t;

    state_t     state, state_next;
    logic       ready, pc_update, branch, taken;
    logic       ir_write, mem_write, reg_write, illegal;
    logic [1:0] alu_op;

    assign ready = USE_MEM_READY ? MemReady : 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= FETCH;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = FETCH;
        pc_update  = 1'b0;
        branch     = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        illegal    = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        alu_op     = 2'b00;
        case (state)
            FETCH: begin
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                ir_write   = ready;
                pc_update  = ready;
                state_next = ready ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    7'b0000011, 7'b0100011: state_next = MEMADR;
                    7'b0110011:             state_next = EXECUTER;
                    7'b0010011:             state_next = EXECUTEI;
                    7'b1100011:             state_next = BRANCH;
                    7'b1101111:             state_next = JAL;
                    7'b1100111:             state_next = JALR;
                    7'b0110111: begin
                        state_next = EN_UTYPE ? LUI : FETCH;
                        illegal    = !EN_UTYPE;
                    end
                    7'b0010111: begin
                        state_next = EN_UTYPE ? AUIPC : FETCH;
                        illegal    = !EN_UTYPE;
                    end
                    default:                illegal = 1'b1;
                endcase
            end
            MEMADR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                state_next = op[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                AdrSrc     = 1'b1;
                state_next = ready ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                reg_write = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc     = 1'b1;
                mem_write  = 1'b1;
                state_next = ready ? FETCH : MEMWRITE;
            end
            EXECUTER: begin
                ALUSrcA    = 2'b10;
                alu_op     = 2'b10;
                state_next = ALUWB;
            end
            EXECUTEI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                alu_op     = 2'b10;
                state_next = ALUWB;
            end
            ALUWB: reg_write = 1'b1;
            BRANCH: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b01;
                branch  = 1'b1;
            end
            // JAL also serves JALR: PC gets the target, ALUOut gets OldPC+4 for the link.
            JAL: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                pc_update  = 1'b1;
                state_next = ALUWB;
            end
            JALR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                state_next = JAL;
            end
            LUI: begin
                ALUSrcA    = 2'b11;
                ALUSrcB    = 2'b01;
                state_next = ALUWB;
            end
            AUIPC: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b01;
                state_next = ALUWB;
            end
            default: state_next = FETCH;
        endcase
    end

    assign taken = (funct3 == 3'b000) ? Zero :
                   (funct3 == 3'b001 && EN_BNE) ? !Zero : 1'b0;

    // Write enables are gated by reset so nothing commits while rst_n is low.
    assign PCWrite      = rst_n & (pc_update | (branch & taken));
    assign IRWrite      = rst_n & ir_write;
    assign MemWrite     = rst_n & mem_write;
    assign RegWrite     = rst_n & reg_write;
    assign IllegalInstr = rst_n & illegal;
    assign State        = state;

    assign ImmSrc = (op == 7'b0100011) ? 3'b001 :
                    (op == 7'b1100011) ? 3'b010 :
                    (op == 7'b1101111) ? 3'b011 :
                    (op == 7'b0110111 || op == 7'b0010111) ? 3'b100 : 3'b000;

    assign ALUControl = (alu_op == 2'b01) ? 3'b001 :
                        (alu_op != 2'b10) ? 3'b000 :
                        (funct3 == 3'b000) ? ((op[5] & funct7b5) ? 3'b001 : 3'b000) :
                        (funct3 == 3'b010) ? 3'b101 :
                        (funct3 == 3'b100) ? 3'b100 :
                        (funct3 == 3'b110) ? 3'b011 :
                        (funct3 == 3'b111) ? 3'b010 : 3'b000;
endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Multicycle successor to the single-cycle control unit, sequencing each RV32I instruction over 3–5 cycles using one shared ALU and one shared memory port. A Moore FSM produces the datapath enables. The ALU decoding follows the existing scheme, extended with XOR. Parameters enable a memory-ready stall handshake, BNE, LUI and AUIPC. An illegal-opcode flag is also provided.

Parameters:
USE_MEM_READY, 1, 1: FETCH/MEMREAD/MEMWRITE wait for MemReady; 0: MemReady ignored (treated as 1)
EN_BNE, 1, 1: Branch funct3=001 (bne) is taken on !Zero; 0: only beq is taken
EN_UTYPE, 1, 1: LUI (0110111) and AUIPC (0010111) are supported; 0: both are illegal

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
op  in  7  opcode from the instruction register
funct3  in  3  instr[14:12]
funct7b5  in  1  instr[30]
Zero  in  1  ALU zero flag
MemReady  in  1  memory access completes this cycle
PCWrite  out  1  PC register enable
AdrSrc  out  1  memory address: 0 = PC, 1 = ALUOut
MemWrite  out  1  data memory write enable
IRWrite  out  1  instruction/OldPC register enable
ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1 (A), 11 = zero
ALUSrcB  out  2  00 = rs2 (WriteData), 01 = ImmExt, 10 = constant 4
RegWrite  out  1  register file write enable
ImmSrc  out  3  000 = I, 001 = S, 010 = B, 011 = J, 100 = U
ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt
IllegalInstr  out  1  one-cycle pulse in DECODE for an unsupported opcode
State  out  4  current state encoding, for debug

Behaviour:
- Clock and reset: single clock `clk`; synchronous active-low reset `rst_n`.
- Reset:
  - While rst_n=0, PCWrite, IRWrite, MemWrite, RegWrite and IllegalInstr are forced to 0.
  - State goes to FETCH at the next clk edge.
  - Reset mid-instruction abandons that instruction; no partial write occurs after the reset edge.
- State encoding:
  - FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7
  - ALUWB=8, BRANCH=9, JAL=10, JALR=11, LUI=12, AUIPC=13
  - Codes 14 and 15 are unreachable; if entered, go to FETCH.
- Per-state outputs (Moore; any signal not listed is 0 or 00; ALUOp is internal):
  - FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite and PCUpdate are asserted only in the cycle MemReady=1. Stays in FETCH while MemReady=0.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00. ALUOut receives OldPC+imm, which is the branch/JAL target.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
  - MEMREAD: AdrSrc=1, ResultSrc=00. Waits on MemReady.
  - MEMWB: ResultSrc=01, RegWrite.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite held every cycle until MemReady=1.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  - ALUWB: ResultSrc=00, RegWrite.
  - BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate. This writes the target to PC and latches OldPC+4 into ALUOut.
  - JALR: ALUSrcA=10, ALUSrcB=01, ALUOp=00; no writes. Clearing bit 0 of the JALR target is done by the datapath.
  - LUI: ALUSrcA=11, ALUSrcB=01, ALUOp=00.
  - AUIPC: ALUSrcA=01, ALUSrcB=01, ALUOp=00.
- Transitions:
  - FETCH→DECODE on MemReady.
  - DECODE dispatches on op:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECUTER
    - 0010011 → EXECUTEI
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 1100111 → JALR
    - 0110111 → LUI (if EN_UTYPE)
    - 0010111 → AUIPC (if EN_UTYPE)
    - else: IllegalInstr=1 and next state FETCH.
  - MEMADR → MEMREAD if op[5]=0, else MEMWRITE.
  - MEMREAD→MEMWB on MemReady; MEMWB→FETCH.
  - MEMWRITE→FETCH on MemReady.
  - EXECUTER, EXECUTEI, LUI, AUIPC → ALUWB; ALUWB→FETCH.
  - BRANCH→FETCH.
  - JALR→JAL, JAL→ALUWB.
- PCWrite = PCUpdate | (Branch & taken).
  - funct3=000: taken = Zero.
  - funct3=001 with EN_BNE: taken = !Zero.
  - All other funct3: not taken.
- ImmSrc is decoded combinationally from op in every state:
  - I for load, OP-IMM and JALR; S for store; B for branch; J for JAL; U for LUI/AUIPC.
  - Default 000 for any other op.
- ALUControl is combinational:
  - ALUOp 00 → add; 01 → sub.
  - ALUOp 10, by funct3:
    - 000 → sub if op[5]&funct7b5, else add
    - 010 → slt
    - 100 → xor
    - 110 → or
    - 111 → and
    - any other funct3 → add

Test Plan:
1. lw, MemReady=1 throughout → states 0,1,2,3,4,0; RegWrite=1 and ResultSrc=01 only in MEMWB; total 5 cycles.
2. sw with MemReady low for 3 cycles in MEMWRITE → MemWrite=1 for 4 consecutive cycles, then FETCH; RegWrite stays 0.
3. FETCH with MemReady=0 for 2 cycles → IRWrite and PCWrite stay 0 until the ready cycle, then pulse for exactly 1 cycle.
4. Branch cases, checked for PCWrite in BRANCH:
   - beq with Zero=1 → PCWrite=1; with Zero=0 → PCWrite=0.
   - bne with Zero=0 → PCWrite=1 when EN_BNE=1, and PCWrite=0 when EN_BNE=0.
5. sub x3,x1,x2 (funct3=000, funct7b5=1) → EXECUTER with ALUControl=001, then ALUWB with RegWrite=1. addi with funct7b5=1 → ALUControl=000.
6. Mixed cases:
   - jalr → states 11,10,8; PCWrite=1 only in JAL.
   - lui with EN_UTYPE=0 → IllegalInstr=1 in DECODE, then FETCH.
   - rst_n=0 asserted during MEMWB → RegWrite=0 that cycle; State=0 on the next edge.
